multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, instruction register and immediate extender over several cycles per instruction.
- Drives ImmSrc to the immediate extender, and per-state mux selects, write enables and ALU control.
- Sits beside the datapath. Inputs: opcode/funct fields from the instruction register, and the ALU zero flag.

---
 rtl/multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core
//
// Sequences the shared ALU, memory port, instruction register and immediate
// extender over several cycles per instruction.
//
// Build option: define MULTICYCLE_UTYPE_EN to execute lui/auipc through the
// EXECUTEU state; without it both opcodes trap as illegal.
//
// Parameter:
//   MEM_WAIT   extra stall cycles held in MEMREAD/MEMWRITE (0..15)
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   op         opcode, IR[6:0]
//   funct3     IR[14:12]
//   funct7b5   IR[30]
//   zero       ALU zero flag
//   PCWrite    PC register enable
//   AdrSrc     memory address select: 0=PC, 1=ALUOut
//   MemWrite   data memory write strobe
//   IRWrite    instruction/OldPC register enable
//   ResultSrc  result mux: 00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA    00=PC, 01=OldPC, 10=rs1 data, 11=zero
//   ALUSrcB    00=rs2 data, 01=ImmExt, 10=constant 4
//   RegWrite   register file write enable
//   ImmSrc     immediate extender format select
//   ALUControl 000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal    sticky illegal-instruction flag
//   state_o    current state encoding, debug
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state_o
);
    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] EXECUTEU = 4'd11;
    localparam logic [3:0] TRAP     = 4'd12;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [3:0]    state;
    logic [3:0]    next_state;
    logic [3:0]    decode_next;
    logic [3:0]    utype_next;
    logic [CW-1:0] wait_cnt;
    logic          wait_done;
    logic          in_mem;
    logic          illegal_q;
    logic          funct_bad;
    logic          set_illegal;
    logic          is_utype;
    logic [1:0]    alu_op;
    logic [2:0]    funct_ctrl;
    logic          pc_write;
    logic          ir_write;
    logic          mem_write;
    logic          reg_write;
    logic          adr_src;
    logic [1:0]    result_src;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;

    assign is_utype = (op == OP_LUI) || (op == OP_AUIPC);

`ifdef MULTICYCLE_UTYPE_EN
    assign utype_next = EXECUTEU;
`else
    assign utype_next = TRAP;
`endif

    assign decode_next = (op == OP_LW || op == OP_SW) ? MEMADR   :
                         (op == OP_R)                 ? EXECUTER :
                         (op == OP_I)                 ? EXECUTEI :
                         (op == OP_BEQ)               ? BEQ      :
                         (op == OP_JAL)               ? JAL      :
                         is_utype                     ? utype_next : TRAP;

    assign in_mem    = (state == MEMREAD) || (state == MEMWRITE);
    assign wait_done = (wait_cnt == WAIT_LAST);

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE:   next_state = decode_next;
            // Only lw/sw reach MEMADR; op[5] separates store from load.
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = wait_done ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = wait_done ? FETCH : MEMWRITE;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
`ifdef MULTICYCLE_UTYPE_EN
            EXECUTEU: next_state = ALUWB;
`endif
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    // Unsupported funct3 values still execute as add but mark the core illegal.
    assign funct_bad = !(funct3 == 3'b000 || funct3 == 3'b010 ||
                         funct3 == 3'b110 || funct3 == 3'b111);

    assign set_illegal = (next_state == TRAP) ||
                         ((state == DECODE) && funct_bad &&
                          (next_state == EXECUTER || next_state == EXECUTEI));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= (in_mem && !wait_done) ? wait_cnt + CW'(1) : '0;
            illegal_q <= illegal_q | set_illegal;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            // ALUOut captures OldPC + imm here as the branch/jump target.
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            // The strobe is held back to the last wait cycle so slow memory sees one write.
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = wait_done;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
`ifdef MULTICYCLE_UTYPE_EN
            // lui adds the immediate to zero, auipc to OldPC; op[5] tells them apart.
            EXECUTEU: begin
                alu_src_a = op[5] ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
            end
`endif
            default: ;
        endcase
    end

    // sub applies only to R-type; I-type bit 30 belongs to the immediate.
    assign funct_ctrl = (funct3 == 3'b000) ? {2'b00, funct7b5 & op[5]} :
                        (funct3 == 3'b010) ? 3'b101 :
                        (funct3 == 3'b110) ? 3'b011 :
                        (funct3 == 3'b111) ? 3'b010 : 3'b000;

    assign ALUControl = (alu_op == 2'b00) ? 3'b000 :
                        (alu_op == 2'b01) ? 3'b001 : funct_ctrl;

    // lui/auipc share code 01 with stores; the extender picks U format from IR[4].
    assign ImmSrc = (op == OP_SW || is_utype) ? 2'b01 :
                    (op == OP_BEQ)            ? 2'b10 :
                    (op == OP_JAL)            ? 2'b11 : 2'b00;

    assign PCWrite   = pc_write  & ~reset;
    assign IRWrite   = ir_write  & ~reset;
    assign MemWrite  = mem_write & ~reset;
    assign RegWrite  = reg_write & ~reset;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign illegal   = illegal_q;
    assign state_o   = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;

    logic       pcw0, adr0, mw0, irw0, rw0, ill0;
    logic [1:0] rs0, asa0, asb0, imm0;
    logic [2:0] aluc0;
    logic [3:0] st0;
    logic       pcw3, adr3, mw3, irw3, rw3, ill3;
    logic [1:0] rs3, asa3, asb3, imm3;
    logic [2:0] aluc3;
    logic [3:0] st3;

    int passed = 0;
    int fails = 0;
    int total = 0;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0),
        .ALUSrcA(asa0), .ALUSrcB(asb0), .RegWrite(rw0), .ImmSrc(imm0), .ALUControl(aluc0),
        .illegal(ill0), .state_o(st0)
    );

    multicycle_ctrl #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(pcw3), .AdrSrc(adr3), .MemWrite(mw3), .IRWrite(irw3), .ResultSrc(rs3),
        .ALUSrcA(asa3), .ALUSrcB(asb3), .RegWrite(rw3), .ImmSrc(imm3), .ALUControl(aluc3),
        .illegal(ill3), .state_o(st3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_sync;
        reset = 1'b1;
        tick;
        chk("rst_state0", 8'(st0), 8'd0);
        chk("rst_state3", 8'(st3), 8'd0);
        chk("rst_pcw_forced", 8'(pcw0), 8'd0);
        chk("rst_irw_forced", 8'(irw3), 8'd0);
        chk("rst_illegal0", 8'(ill0), 8'd0);
        chk("rst_illegal3", 8'(ill3), 8'd0);
        reset = 1'b0;
        #1;
    endtask

    logic [6:0] t_op [6] = '{OP_R, OP_I, OP_R, OP_R, OP_I, OP_R};
    logic [2:0] t_f3 [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
    logic       t_f7 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] t_ac [6] = '{3'b001, 3'b000, 3'b000, 3'b101, 3'b011, 3'b010};

    initial begin
        tick;
        tick;
        chk("reset_state", 8'(st0), 8'd0);
        chk("reset_pcw", 8'(pcw0), 8'd0);
        chk("reset_irw", 8'(irw0), 8'd0);
        chk("reset_illegal", 8'(ill0), 8'd0);
        reset = 1'b0;
        op = OP_LW;
        funct3 = 3'b010;
        #1;
        chk("fetch_pcw", 8'(pcw0), 8'd1);
        chk("fetch_irw", 8'(irw0), 8'd1);
        chk("fetch_asb", 8'(asb0), 8'd2);
        chk("fetch_rs", 8'(rs0), 8'd2);
        chk("fetch_adr", 8'(adr0), 8'd0);
        chk("lw_imm", 8'(imm0), 8'd0);
        tick;
        chk("lw_decode", 8'(st0), 8'd1);
        chk("decode_asa", 8'(asa0), 8'd1);
        chk("decode_asb", 8'(asb0), 8'd1);
        chk("decode_irw", 8'(irw0), 8'd0);
        tick;
        chk("lw_memadr", 8'(st0), 8'd2);
        chk("memadr_asa", 8'(asa0), 8'd2);
        tick;
        chk("lw_memread", 8'(st0), 8'd3);
        chk("memread_adr", 8'(adr0), 8'd1);
        chk("memread_rw", 8'(rw0), 8'd0);
        chk("lw_memread3", 8'(st3), 8'd3);
        tick;
        chk("lw_memwb", 8'(st0), 8'd4);
        chk("memwb_rw", 8'(rw0), 8'd1);
        chk("memwb_rs", 8'(rs0), 8'd1);
        chk("lw3_hold", 8'(st3), 8'd3);
        tick;
        chk("lw_done", 8'(st0), 8'd0);
        chk("lw3_hold2", 8'(st3), 8'd3);
        rst_sync;

        op = OP_SW;
        #1;
        chk("sw_imm", 8'(imm3), 8'd1);
        tick;
        tick;
        chk("sw_memadr3", 8'(st3), 8'd2);
        tick;
        chk("sw_mw0_only", 8'(mw0), 8'd1);
        chk("sw3_state_c0", 8'(st3), 8'd5);
        chk("sw3_mw_c0", 8'(mw3), 8'd0);
        chk("sw3_adr", 8'(adr3), 8'd1);
        tick;
        chk("sw0_done", 8'(st0), 8'd0);
        chk("sw3_state_c1", 8'(st3), 8'd5);
        chk("sw3_mw_c1", 8'(mw3), 8'd0);
        tick;
        chk("sw3_mw_c2", 8'(mw3), 8'd0);
        tick;
        chk("sw3_state_c3", 8'(st3), 8'd5);
        chk("sw3_mw_c3", 8'(mw3), 8'd1);
        tick;
        chk("sw3_done", 8'(st3), 8'd0);
        chk("sw3_mw_after", 8'(mw3), 8'd0);
        rst_sync;

        op = OP_BEQ;
        funct3 = 3'b000;
        zero = 1'b1;
        #1;
        chk("beq_imm", 8'(imm0), 8'd2);
        tick;
        tick;
        chk("beq_state", 8'(st0), 8'd9);
        chk("beq_pcw_z1", 8'(pcw0), 8'd1);
        chk("beq_aluc", 8'(aluc0), 8'd1);
        chk("beq_asa", 8'(asa0), 8'd2);
        zero = 1'b0;
        #1;
        chk("beq_pcw_z0", 8'(pcw0), 8'd0);
        tick;
        chk("beq_done", 8'(st0), 8'd0);

        for (int i = 0; i < 6; i++) begin
            op = t_op[i];
            funct3 = t_f3[i];
            funct7b5 = t_f7[i];
            tick;
            tick;
            chk("alu_exec_state", 8'(st0), (t_op[i] == OP_R) ? 8'd6 : 8'd7);
            chk("alu_control", 8'(aluc0), 8'(t_ac[i]));
            chk("alu_asb", 8'(asb0), (t_op[i] == OP_R) ? 8'd0 : 8'd1);
            chk("alu_illegal", 8'(ill0), 8'd0);
            tick;
            chk("aluwb_state", 8'(st0), 8'd8);
            chk("aluwb_rw", 8'(rw0), 8'd1);
            tick;
            chk("alu_done", 8'(st0), 8'd0);
        end

        op = OP_JAL;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        #1;
        chk("jal_imm", 8'(imm0), 8'd3);
        tick;
        tick;
        chk("jal_state", 8'(st0), 8'd10);
        chk("jal_pcw", 8'(pcw0), 8'd1);
        chk("jal_asa", 8'(asa0), 8'd1);
        chk("jal_asb", 8'(asb0), 8'd2);
        tick;
        chk("jal_aluwb", 8'(st0), 8'd8);
        chk("jal_rw", 8'(rw0), 8'd1);
        tick;
        chk("jal_done", 8'(st0), 8'd0);

        op = OP_R;
        funct3 = 3'b001;
        tick;
        chk("badf_decode_ill", 8'(ill0), 8'd0);
        tick;
        chk("badf_state", 8'(st0), 8'd6);
        chk("badf_ill", 8'(ill0), 8'd1);
        chk("badf_aluc", 8'(aluc0), 8'd0);
        tick;
        tick;
        chk("badf_sticky", 8'(ill0), 8'd1);
        rst_sync;

        op = OP_LUI;
        funct3 = 3'b000;
        #1;
        chk("lui_imm", 8'(imm0), 8'd1);
        tick;
        tick;
`ifdef MULTICYCLE_UTYPE_EN
        chk("lui_state", 8'(st0), 8'd11);
        chk("lui_asa", 8'(asa0), 8'd3);
        chk("lui_asb", 8'(asb0), 8'd1);
        chk("lui_ill", 8'(ill0), 8'd0);
        tick;
        chk("lui_aluwb", 8'(st0), 8'd8);
        chk("lui_rw", 8'(rw0), 8'd1);
        tick;
        chk("lui_done", 8'(st0), 8'd0);
`else
        chk("lui_trap", 8'(st0), 8'd12);
        chk("lui_ill", 8'(ill0), 8'd1);
        chk("lui_rw", 8'(rw0), 8'd0);
        chk("lui_pcw", 8'(pcw0), 8'd0);
        tick;
        chk("lui_trap_hold", 8'(st0), 8'd12);
        chk("lui_irw", 8'(irw0), 8'd0);
        chk("lui_ill_hold", 8'(ill0), 8'd1);
`endif
        rst_sync;

        op = 7'b0000000;
        tick;
        tick;
        chk("unk_trap", 8'(st0), 8'd12);
        chk("unk_ill", 8'(ill0), 8'd1);
        tick;
        chk("unk_trap_hold", 8'(st0), 8'd12);
        chk("unk_mw", 8'(mw0), 8'd0);
        rst_sync;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
